fib_sequencer: RTL and testbench
================================

Name: fib_sequencer

Overview:
Multi-byte Fibonacci engine that sequences the shared 8-bit ALU (add-with-carry, opcode 0) byte-serially to compute F(n) at 8*BYTES bits. The ALU is combinational and sits outside this block. The block drives the ALU operand, carry and opcode ports and captures its result and carry-out in the same cycle. It sits between the analyzer's command interface and the ALU, and uses a start/done handshake.

Parameters:
BYTES, 2, number of 8-bit limbs in each Fibonacci operand (result width W = 8*BYTES); legal range 1..8

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  request; sampled only in IDLE
n  in  8  index of the Fibonacci term to compute; latched when start is accepted
busy  out  1  high from the cycle after start is accepted until DONE
done  out  1  one-cycle pulse; fib and overflow are valid from this cycle
fib  out  W  result F(n), or the truncated sum on overflow; held until the next accepted start
overflow  out  1  set if an addition carried out of bit W-1; held with fib
even_count  out  8  number of even terms among F(0)..F(n) computed (see Optional Feature)
alu_left  out  8  current limb of operand a
alu_right  out  8  current limb of operand b
alu_status_in  out  1  carry into the current limb
alu_opcode  out  2  constant 2'b00 (add with carry)
alu_result  in  8  ALU sum limb, combinational
alu_status_out  in  1  ALU carry-out, combinational

Behaviour:
- Reset: state=IDLE; busy=0, done=0, fib=0, overflow=0, even_count=0, alu_left=0, alu_right=0, alu_status_in=0, alu_opcode=0; internal registers a, b, sum, carry, limb index and term counter all cleared.
- Reset mid-operation aborts immediately to the reset state. No done pulse is produced.
- States: IDLE, ADD, DONE.
- IDLE:
  - On start=1 in cycle T: latch n, set a=0 (F0), b=1 (F1), limb k=0, carry=0, term counter i=2.
  - If n<=1, go to DONE with fib=n.
  - Otherwise go to ADD.
- ADD, one limb per cycle, LSB limb first:
  - alu_left = a[8k+7:8k], alu_right = b[8k+7:8k].
  - alu_status_in = 0 when k=0, otherwise the registered carry.
  - sum limb k <= alu_result; carry <= alu_status_out.
- End of the last limb (k=BYTES-1):
  - Form new = {alu_result, sum lower limbs}.
  - If alu_status_out=1: fib=new, overflow=1, go to DONE. The remaining terms are skipped.
  - Else if i==n: fib=new, go to DONE.
  - Else: a<=b, b<=new, i<=i+1, k<=0, and stay in ADD.
- ALU outputs are registered from state and k. Operands must be stable during the ADD cycle they are used in. In IDLE and DONE the ALU outputs are 0.
- Latency: with start accepted at T, DONE (done=1) occurs at T+1+max(n-1,0)*BYTES without overflow. On overflow at term j, DONE occurs at T+1+(j-1)*BYTES.
- DONE lasts exactly one cycle, then returns to IDLE. busy=0 in DONE.
- start is ignored while in ADD or DONE, and n changes are ignored after latch.
- Width arithmetic: all additions are modulo 2^W. overflow is sticky only within one run and is cleared when the next start is accepted.

Optional Feature:
- Macro FIB_EVEN_COUNT_EN.
- When defined:
  - even_count is set to 1 at start (F0 is even), or 1 for n=1.
  - It increments by one for each completed term whose bit 0 is 0.
  - This includes the overflowing term, which is tested on its truncated value.
  - It saturates at 255 and is held with fib.
- When undefined: even_count is tied to 0 and no counter logic is built.

Test Plan:
- BYTES=2, start with n=0 at T -> done=1 at T+1, fib=0, overflow=0; n=1 -> fib=1 at T+1.
- BYTES=2, n=10 -> done at T+19, fib=55, overflow=0. alu_status_in=0 on limb 0 and equals the registered carry on limb 1 for every term.
- BYTES=1, n=13 -> fib=233, overflow=0, done at T+13. n=14 -> fib=121 (377 mod 256), overflow=1, done at T+14. n=20 -> the same fib=121 and overflow=1, with early done at T+14.
- BYTES=2, n=24 -> fib=46368, overflow=0. n=25 -> fib=9489 (75025 mod 65536), overflow=1, done at T+49.
- BYTES=2, n=10 with start re-pulsed and n changed during ADD -> ignored, result is still 55. Then rst asserted mid-run at T+5 -> the next cycle shows IDLE, all outputs 0, and no done pulse.
- With FIB_EVEN_COUNT_EN, n=10 -> even_count=4 (F0, F3, F6, F9). Without the macro, even_count stays 0 throughout.

Source files
------------

// File: rtl/fib_sequencer.sv
// Byte-serial multi-limb Fibonacci engine driving an external combinational 8-bit adder.
// Optional even-term counter is built only when FIB_EVEN_COUNT_EN is defined.
module fib_sequencer #(
  parameter int BYTES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           n,
  output logic                 busy,
  output logic                 done,
  output logic [8*BYTES-1:0]   fib,
  output logic                 overflow,
  output logic [7:0]           even_count,
  output logic [7:0]           alu_left,
  output logic [7:0]           alu_right,
  output logic                 alu_status_in,
  output logic [1:0]           alu_opcode,
  input  logic [7:0]           alu_result,
  input  logic                 alu_status_out
);

  localparam int W  = 8 * BYTES;
  localparam int KW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic [W-1:0]    sum;
  logic [KW-1:0]   k;
  logic [7:0]      i;
  logic [7:0]      n_q;

  logic            last_limb;
  logic            start_acc;
  logic            term_done;
  logic [W-1:0]    new_val;
  int              k_int;
  int              k_next;

  assign alu_opcode = 2'b00;

  always_comb begin
    k_int     = int'(k);
    k_next    = k_int + 1;
    last_limb = (k == K_LAST);
    start_acc = (state == S_IDLE) && start;
    term_done = (state == S_ADD) && last_limb;
    new_val   = sum;
    new_val[8*(BYTES-1) +: 8] = alu_result;
  end

  // alu_status_in doubles as the registered inter-limb carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      fib           <= '0;
      overflow      <= 1'b0;
      alu_left      <= 8'd0;
      alu_right     <= 8'd0;
      alu_status_in <= 1'b0;
      a             <= '0;
      b             <= '0;
      sum           <= '0;
      k             <= '0;
      i             <= 8'd0;
      n_q           <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          alu_left      <= 8'd0;
          alu_right     <= 8'd0;
          alu_status_in <= 1'b0;
          if (start) begin
            n_q      <= n;
            a        <= '0;
            b        <= W'(1);
            sum      <= '0;
            k        <= '0;
            i        <= 8'd2;
            overflow <= 1'b0;
            if (n <= 8'd1) begin
              fib   <= {{(W-1){1'b0}}, n[0]};
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              fib       <= '0;
              busy      <= 1'b1;
              alu_left  <= 8'd0;
              alu_right <= 8'd1;
              state     <= S_ADD;
            end
          end
        end

        S_ADD: begin
          sum[8*k_int +: 8] <= alu_result;
          if (!last_limb) begin
            k             <= k + KW'(1);
            alu_left      <= a[8*k_next +: 8];
            alu_right     <= b[8*k_next +: 8];
            alu_status_in <= alu_status_out;
          end else if (alu_status_out || (i == n_q)) begin
            fib           <= new_val;
            overflow      <= alu_status_out;
            done          <= 1'b1;
            busy          <= 1'b0;
            alu_left      <= 8'd0;
            alu_right     <= 8'd0;
            alu_status_in <= 1'b0;
            state         <= S_DONE;
          end else begin
            a             <= b;
            b             <= new_val;
            i             <= i + 8'd1;
            k             <= '0;
            alu_left      <= b[7:0];
            alu_right     <= new_val[7:0];
            alu_status_in <= 1'b0;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIB_EVEN_COUNT_EN
  logic [7:0] even_q;

  assign even_count = even_q;

  // The overflowing term counts too, judged on its truncated value.
  always_ff @(posedge clk) begin
    if (rst) begin
      even_q <= 8'd0;
    end else if (start_acc) begin
      even_q <= 8'd1;
    end else if (term_done && !new_val[0] && (even_q != 8'hFF)) begin
      even_q <= even_q + 8'd1;
    end
  end
`else
  logic unused_even;

  assign unused_even = start_acc ^ term_done;
  assign even_count  = 8'd0;
`endif

endmodule

// File: tb/tb_fib_sequencer.sv
// Self-checking bench for fib_sequencer: BYTES=1 and BYTES=2 instances, each with a
// behavioural adder, checked against an arithmetic Fibonacci reference.
module tb_fib_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic go  = 1'b0;
  logic [7:0] nin = 8'd0;
  int sel = 2;

  int errors = 0;
  int checks = 0;

  longint unsigned fibs [0:90];

  always #5 clk = ~clk;

  logic        x1_start, x1_busy, x1_done, x1_ovf, x1_sin, x1_sout;
  logic [7:0]  x1_fib, x1_ec, x1_left, x1_right, x1_res;
  logic [1:0]  x1_op;
  logic        x2_start, x2_busy, x2_done, x2_ovf, x2_sin, x2_sout;
  logic [15:0] x2_fib;
  logic [7:0]  x2_ec, x2_left, x2_right, x2_res;
  logic [1:0]  x2_op;

  assign x1_start = go && (sel == 1);
  assign x2_start = go && (sel == 2);

  always_comb {x1_sout, x1_res} = 9'(x1_left) + 9'(x1_right) + 9'(x1_sin);
  always_comb {x2_sout, x2_res} = 9'(x2_left) + 9'(x2_right) + 9'(x2_sin);

  fib_sequencer #(.BYTES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(x1_start), .n(nin),
    .busy(x1_busy), .done(x1_done), .fib(x1_fib), .overflow(x1_ovf),
    .even_count(x1_ec), .alu_left(x1_left), .alu_right(x1_right),
    .alu_status_in(x1_sin), .alu_opcode(x1_op),
    .alu_result(x1_res), .alu_status_out(x1_sout)
  );

  fib_sequencer #(.BYTES(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(x2_start), .n(nin),
    .busy(x2_busy), .done(x2_done), .fib(x2_fib), .overflow(x2_ovf),
    .even_count(x2_ec), .alu_left(x2_left), .alu_right(x2_right),
    .alu_status_in(x2_sin), .alu_opcode(x2_op),
    .alu_result(x2_res), .alu_status_out(x2_sout)
  );

  logic        o_busy, o_done, o_ovf, o_sin;
  logic [63:0] o_fib;
  logic [7:0]  o_ec, o_left, o_right;
  logic [1:0]  o_op;

  always_comb begin
    if (sel == 1) begin
      o_busy = x1_busy; o_done = x1_done; o_ovf = x1_ovf; o_sin = x1_sin;
      o_fib = 64'(x1_fib); o_ec = x1_ec; o_left = x1_left; o_right = x1_right; o_op = x1_op;
    end else begin
      o_busy = x2_busy; o_done = x2_done; o_ovf = x2_ovf; o_sin = x2_sin;
      o_fib = 64'(x2_fib); o_ec = x2_ec; o_left = x2_left; o_right = x2_right; o_op = x2_op;
    end
  end

  // Reference: exact Fibonacci terms, stop at the first term that does not fit in W bits.
  task automatic model(input int bytes, input int nn, output longint unsigned f,
                       output bit ov, output int lat, output int ec);
    longint unsigned m = 64'd1 << (8 * bytes);
    ov = 1'b0;
    ec = 1;
    if (nn <= 1) begin
      f = longint'(nn);
      lat = 1;
    end else begin
      f = 0;
      lat = 1 + (nn - 1) * bytes;
      for (int j = 2; j <= nn; j++) begin
        longint unsigned t = fibs[j] % m;
        if (t[0] == 1'b0) ec++;
        f = t;
        if (fibs[j] >= m) begin
          ov = 1'b1;
          lat = 1 + (j - 1) * bytes;
          break;
        end
      end
    end
    if (ec > 255) ec = 255;
`ifndef FIB_EVEN_COUNT_EN
    ec = 0;
`endif
  endtask

  task automatic run_case(input int nn, input bit glitch);
    longint unsigned ef;
    bit eov;
    int elat, eec, c;
    int bytes = sel;
    model(bytes, nn, ef, eov, elat, eec);
    @(negedge clk);
    nin = 8'(nn);
    go  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    go = 1'b0;
    c  = 1;
    while (!o_done && c < 3000) begin
      int t = 2 + (c - 1) / bytes;
      int l = (c - 1) % bytes;
      longint unsigned ea, eb, mask;
      logic [7:0] el, er;
      logic ecin;
      if (t > 90) t = 90;
      ea = fibs[t-2];
      eb = fibs[t-1];
      mask = (64'd1 << (8 * l)) - 64'd1;
      el = 8'(ea >> (8 * l));
      er = 8'(eb >> (8 * l));
      ecin = (l == 0) ? 1'b0 : 1'(((ea & mask) + (eb & mask)) >> (8 * l));
      checks++;
      if (o_busy !== 1'b1 || o_left !== el || o_right !== er || o_sin !== ecin || o_op !== 2'b00) begin
        errors++;
        $display("FAIL add_cycle n=%0d c=%0d: busy=%b left=%h right=%h cin=%b op=%b, required busy=1 left=%h right=%h cin=%b op=00",
                 nn, c, o_busy, o_left, o_right, o_sin, o_op, el, er, ecin);
      end
      if (glitch && c == 3) begin
        go  = 1'b1;
        nin = 8'($urandom_range(2, 40));
      end else if (glitch && c == 4) begin
        go = 1'b0;
      end
      @(negedge clk);
      c++;
    end
    go = 1'b0;
    checks++;
    if (!o_done) begin
      errors++;
      $display("FAIL done_timeout n=%0d bytes=%0d: no done after %0d cycles, required at %0d", nn, bytes, c, elat);
    end
    checks++;
    if (c != elat) begin
      errors++;
      $display("FAIL latency n=%0d bytes=%0d: done at T+%0d, required T+%0d", nn, bytes, c, elat);
    end
    checks++;
    if (o_fib !== ef || o_ovf !== eov) begin
      errors++;
      $display("FAIL result n=%0d bytes=%0d: fib=%0d ovf=%b, required fib=%0d ovf=%b", nn, bytes, o_fib, o_ovf, ef, eov);
    end
    checks++;
    if (o_ec !== 8'(eec)) begin
      errors++;
      $display("FAIL even_count n=%0d bytes=%0d: got %0d, required %0d", nn, bytes, o_ec, eec);
    end
    checks++;
    if (o_busy !== 1'b0 || o_left !== 8'd0 || o_right !== 8'd0 || o_sin !== 1'b0) begin
      errors++;
      $display("FAIL done_outputs n=%0d: busy=%b left=%h right=%h cin=%b, required all 0", nn, o_busy, o_left, o_right, o_sin);
    end
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0 || o_fib !== ef || o_ovf !== eov || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL after_done n=%0d: done=%b fib=%0d ovf=%b busy=%b, required done=0 fib=%0d ovf=%b busy=0",
               nn, o_done, o_fib, o_ovf, o_busy, ef, eov);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 1; s <= 2; s++) begin
      sel = s;
      #1;
      checks++;
      if (o_busy !== 0 || o_done !== 0 || o_fib !== 0 || o_ovf !== 0 || o_ec !== 0 ||
          o_left !== 0 || o_right !== 0 || o_sin !== 0 || o_op !== 0) begin
        errors++;
        $display("FAIL reset_state bytes=%0d: busy=%b done=%b fib=%0d ovf=%b ec=%0d left=%h right=%h cin=%b op=%b, required all 0",
                 s, o_busy, o_done, o_fib, o_ovf, o_ec, o_left, o_right, o_sin, o_op);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_small_n();
    sel = 2;
    run_case(0, 1'b0);
    run_case(1, 1'b0);
    sel = 1;
    run_case(0, 1'b0);
    run_case(1, 1'b0);
    run_case(2, 1'b0);
  endtask

  task automatic test_nominal();
    sel = 2;
    run_case(10, 1'b0);
    run_case(24, 1'b0);
    sel = 1;
    run_case(13, 1'b0);
  endtask

  task automatic test_overflow();
    sel = 1;
    run_case(14, 1'b0);
    run_case(20, 1'b0);
    run_case(255, 1'b0);
    sel = 2;
    run_case(25, 1'b0);
    run_case(40, 1'b0);
  endtask

  task automatic test_ignore_start();
    sel = 2;
    run_case(10, 1'b1);
    sel = 1;
    run_case(12, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 16; r++) begin
      sel = ($urandom_range(0, 1) == 0) ? 1 : 2;
      run_case((sel == 1) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 30)), 1'b0);
    end
  endtask

  task automatic test_mid_reset();
    int seen_done = 0;
    sel = 2;
    @(negedge clk);
    nin = 8'd10;
    go  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    go = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (o_busy !== 0 || o_done !== 0 || o_fib !== 0 || o_ovf !== 0 || o_ec !== 0 ||
        o_left !== 0 || o_right !== 0 || o_sin !== 0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b done=%b fib=%0d ovf=%b ec=%0d left=%h right=%h cin=%b, required all 0",
               o_busy, o_done, o_fib, o_ovf, o_ec, o_left, o_right, o_sin);
    end
    rst = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (o_done || o_busy) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("FAIL mid_reset_quiet: %0d cycles with done/busy after abort, required 0", seen_done);
    end
    run_case(10, 1'b0);
  endtask

  initial begin
    fibs[0] = 0;
    fibs[1] = 1;
    for (int j = 2; j <= 90; j++) fibs[j] = fibs[j-1] + fibs[j-2];
    test_reset();
    test_small_n();
    test_nominal();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
